// File: rtl/stopwatch_counter_pkg.sv
// Shared types and digit limits for the MM:SS.CC stopwatch.
package stopwatch_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

    localparam logic [6:0] CS_MAX       = 7'd99;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] MIN_TENS_MAX = 4'd5;
    localparam logic [3:0] BCD_MAX      = 4'd9;

    typedef struct packed {
        logic [3:0] min_tens;
        logic [3:0] min_ones;
        logic [3:0] sec_tens;
        logic [3:0] sec_ones;
        logic [3:0] cs_tens;
        logic [3:0] cs_ones;
    } bcd_time_t;

endpackage

// File: rtl/stopwatch_counter_if.sv
// Control pulses in, BCD display digits and status out.
interface stopwatch_counter_if;

    logic       tick_in;
    logic       start_stop;
    logic       clear;
    logic       lap;
    logic [3:0] cs_ones;
    logic [3:0] cs_tens;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic       running;
    logic       overflow;

    modport master (
        output tick_in, start_stop, clear, lap,
        input  cs_ones, cs_tens, sec_ones, sec_tens, min_ones, min_tens, running, overflow
    );

    modport slave (
        input  tick_in, start_stop, clear, lap,
        output cs_ones, cs_tens, sec_ones, sec_tens, min_ones, min_tens, running, overflow
    );

endinterface

// File: rtl/stopwatch_counter_bcd_digit_counter.sv
// One BCD digit that wraps at MAX; carry_out is combinational so a whole chain ripples in one cycle.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter logic [3:0] MAX = BCD_MAX
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] q,
    output logic       carry_out
);

    logic [3:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= (count == MAX) ? '0 : count + 4'd1;
        end
    end

    assign q         = count;
    assign carry_out = inc && (count == MAX);

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS.CC stopwatch driven by a synchronised, edge-detected tick_in level.
// Define STOPWATCH_LAP_HOLD_EN to enable the lap display hold.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int TICKS_PER_CS = 10,
    parameter int PRESC_W      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    stopwatch_counter_if.slave  bus
);

    localparam logic [PRESC_W-1:0] TC_LAST = PRESC_W'(TICKS_PER_CS - 1);

    logic               s1, s2, prev;
    logic               tick_pulse;
    state_t             state;
    logic [PRESC_W-1:0] presc;
    logic               running_q;
    logic               overflow_q;
    logic               cs_step;
    logic [5:0]         carry;
    bcd_time_t          live;
    bcd_time_t          disp;

    assign tick_pulse = s2 & ~prev;
    assign cs_step    = (state == RUN) && tick_pulse && !bus.clear && (presc == TC_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            prev       <= 1'b0;
            state      <= IDLE;
            presc      <= '0;
            running_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            s1   <= bus.tick_in;
            s2   <= s1;
            prev <= s2;
            if (bus.clear) begin
                state      <= IDLE;
                presc      <= '0;
                running_q  <= 1'b0;
                overflow_q <= 1'b0;
            end else begin
                // The tick is applied under the state held before any start_stop at this edge.
                if (state == RUN && tick_pulse) begin
                    presc <= (presc == TC_LAST) ? '0 : presc + PRESC_W'(1);
                end
                if (carry[5]) begin
                    overflow_q <= 1'b1;
                end
                if (bus.start_stop) begin
                    case (state)
                        IDLE:    begin state <= RUN;    running_q <= 1'b1; end
                        RUN:     begin state <= PAUSED; running_q <= 1'b0; end
                        PAUSED:  begin state <= RUN;    running_q <= 1'b1; end
                        default: begin state <= IDLE;   running_q <= 1'b0; end
                    endcase
                end
            end
        end
    end

    bcd_digit_counter #(.MAX(4'(CS_MAX % 10))) u_cs_ones (
        .clk(clk), .rst_n(rst_n), .clr(bus.clear), .inc(cs_step),
        .q(live.cs_ones), .carry_out(carry[0])
    );
    bcd_digit_counter #(.MAX(4'(CS_MAX / 10))) u_cs_tens (
        .clk(clk), .rst_n(rst_n), .clr(bus.clear), .inc(carry[0]),
        .q(live.cs_tens), .carry_out(carry[1])
    );
    bcd_digit_counter #(.MAX(BCD_MAX)) u_sec_ones (
        .clk(clk), .rst_n(rst_n), .clr(bus.clear), .inc(carry[1]),
        .q(live.sec_ones), .carry_out(carry[2])
    );
    bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk(clk), .rst_n(rst_n), .clr(bus.clear), .inc(carry[2]),
        .q(live.sec_tens), .carry_out(carry[3])
    );
    bcd_digit_counter #(.MAX(BCD_MAX)) u_min_ones (
        .clk(clk), .rst_n(rst_n), .clr(bus.clear), .inc(carry[3]),
        .q(live.min_ones), .carry_out(carry[4])
    );
    bcd_digit_counter #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clk(clk), .rst_n(rst_n), .clr(bus.clear), .inc(carry[4]),
        .q(live.min_tens), .carry_out(carry[5])
    );

`ifdef STOPWATCH_LAP_HOLD_EN
    logic      hold;
    bcd_time_t snap;

    // Counting carries on underneath the hold; only the digit outputs freeze.
    always_ff @(posedge clk) begin
        if (!rst_n || bus.clear) begin
            hold <= 1'b0;
            snap <= '0;
        end else if (bus.lap) begin
            if (state == RUN) begin
                hold <= ~hold;
                if (!hold) begin
                    snap <= live;
                end
            end else if (state == PAUSED) begin
                hold <= 1'b0;
            end
        end
    end

    assign disp = hold ? snap : live;
`else
    logic unused_lap;
    assign unused_lap = bus.lap;
    assign disp       = live;
`endif

    assign bus.cs_ones  = disp.cs_ones;
    assign bus.cs_tens  = disp.cs_tens;
    assign bus.sec_ones = disp.sec_ones;
    assign bus.sec_tens = disp.sec_tens;
    assign bus.min_ones = disp.min_ones;
    assign bus.min_tens = disp.min_tens;
    assign bus.running  = running_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: dut1 at 10 ticks/cs, dut2 at 1 tick/cs for the long-range cases.
module tb_stopwatch_counter;
    import stopwatch_pkg::*;

`ifdef STOPWATCH_LAP_HOLD_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    typedef struct {
        int          dsel;
        int          edges;
        bit          ss;
        bit          clr;
        bit          lap;
        logic [23:0] t;
        bit          run;
        bit          ovf;
    } vec_t;

    typedef struct {
        string       name;
        logic [23:0] t;
        bit          run;
        bit          ovf;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1_n;
    logic rst2_n;
    int   n_vec  = 0;
    int   n_fail = 0;
    vec_t vecs[$];
    exp_t sb[$];

    stopwatch_counter_if sw1 ();
    stopwatch_counter_if sw2 ();

    stopwatch_counter #(.TICKS_PER_CS(10), .PRESC_W(8)) dut1 (
        .clk(clk), .rst_n(rst1_n), .bus(sw1)
    );
    stopwatch_counter #(.TICKS_PER_CS(1), .PRESC_W(8)) dut2 (
        .clk(clk), .rst_n(rst2_n), .bus(sw2)
    );

    function automatic logic [23:0] time_of(input int d);
        if (d == 1)
            return {sw1.min_tens, sw1.min_ones, sw1.sec_tens, sw1.sec_ones, sw1.cs_tens, sw1.cs_ones};
        return {sw2.min_tens, sw2.min_ones, sw2.sec_tens, sw2.sec_ones, sw2.cs_tens, sw2.cs_ones};
    endfunction

    function automatic logic run_of(input int d);
        return (d == 1) ? sw1.running : sw2.running;
    endfunction

    function automatic logic ovf_of(input int d);
        return (d == 1) ? sw1.overflow : sw2.overflow;
    endfunction

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_tick(input int d, input logic v);
        if (d == 1) sw1.tick_in = v;
        else        sw2.tick_in = v;
    endtask

    task automatic drive(input int d, input logic ss, input logic clr, input logic lp);
        if (d == 1) begin
            sw1.start_stop = ss; sw1.clear = clr; sw1.lap = lp;
        end else begin
            sw2.start_stop = ss; sw2.clear = clr; sw2.lap = lp;
        end
    endtask

    task automatic ticks(input int d, input int n);
        repeat (n) begin
            set_tick(d, 1'b1);
            cyc(1);
            set_tick(d, 1'b0);
            cyc(1);
        end
    endtask

    task automatic pulse(input int d, input bit ss, input bit clr, input bit lp);
        if (ss || clr || lp) begin
            drive(d, ss, clr, lp);
            cyc(1);
            drive(d, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic add(input int d, input int edges, input bit ss, input bit clr, input bit lp,
                       input logic [23:0] t, input bit run, input bit ovf);
        vec_t v;
        v.dsel = d; v.edges = edges; v.ss = ss; v.clr = clr; v.lap = lp;
        v.t = t; v.run = run; v.ovf = ovf;
        vecs.push_back(v);
    endtask

    task automatic run_vecs(input int lo, input int hi);
        vec_t v;
        exp_t e;
        for (int i = lo; i <= hi; i++) begin
            v      = vecs[i];
            e.name = $sformatf("vec%0d", i);
            e.t    = v.t;
            e.run  = v.run;
            e.ovf  = v.ovf;
            sb.push_back(e);
            ticks(v.dsel, v.edges);
            cyc(3);
            pulse(v.dsel, v.ss, v.clr, v.lap);
            cyc(3);
            e = sb.pop_front();
            check({e.name, " time"},     time_of(v.dsel), e.t);
            check({e.name, " running"},  24'(run_of(v.dsel)), 24'(e.run));
            check({e.name, " overflow"}, 24'(ovf_of(v.dsel)), 24'(e.ovf));
        end
    endtask

    // Pulses tick_in once and asserts the given controls in the cycle whose edge consumes tick_pulse.
    task automatic tick_with(input int d, input logic ss, input logic clr);
        set_tick(d, 1'b1);
        cyc(1);
        set_tick(d, 1'b0);
        cyc(1);
        drive(d, ss, clr, 1'b0);
        cyc(1);
        drive(d, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // dut1, TICKS_PER_CS = 10
        add(1,   5, 0, 0, 0, 24'h000000, 0, 0);
        add(1,   0, 1, 0, 0, 24'h000000, 1, 0);
        add(1,  10, 0, 0, 0, 24'h000001, 1, 0);
        add(1, 990, 0, 0, 0, 24'h000100, 1, 0);
        add(1,   0, 0, 1, 0, 24'h000000, 0, 0);
        add(1,   0, 1, 0, 0, 24'h000000, 1, 0);
        add(1, 370, 0, 0, 0, 24'h000037, 1, 0);
        add(1,   3, 1, 0, 0, 24'h000037, 0, 0);
        add(1,  50, 0, 0, 0, 24'h000037, 0, 0);
        add(1,   0, 1, 0, 0, 24'h000037, 1, 0);
        add(1,   6, 0, 0, 0, 24'h000037, 1, 0);
        add(1,   1, 0, 0, 0, 24'h000038, 1, 0);
        add(1,   0, 0, 1, 0, 24'h000000, 0, 0);
        // dut2, TICKS_PER_CS = 1
        add(2,    0, 1, 0, 0, 24'h000000, 1, 0);
        add(2, 5999, 0, 0, 0, 24'h005999, 1, 0);
        add(2,    1, 0, 0, 0, 24'h010000, 1, 0);
        add(2,    0, 0, 1, 0, 24'h000000, 0, 0);
        add(2,    0, 1, 0, 0, 24'h000000, 1, 0);
        add(2, 1234, 0, 0, 0, 24'h001234, 1, 0);
        add(2,    0, 1, 0, 0, 24'h000000, 1, 0);
        add(2,  100, 0, 0, 0, 24'h000100, 1, 0);
        add(2,    0, 0, 0, 1, 24'h000100, 1, 0);
        add(2,  200, 0, 0, 0, LAP_EN ? 24'h000100 : 24'h000300, 1, 0);
        add(2,    0, 0, 0, 1, 24'h000300, 1, 0);
        add(2,    0, 0, 0, 1, 24'h000300, 1, 0);
        add(2,    5, 0, 0, 0, LAP_EN ? 24'h000300 : 24'h000305, 1, 0);
        add(2,    0, 0, 1, 0, 24'h000000, 0, 0);
        add(2,    0, 0, 0, 1, 24'h000000, 0, 0);
        add(2,    0, 1, 0, 0, 24'h000000, 1, 0);
        add(2,    7, 0, 0, 0, 24'h000007, 1, 0);

        sw1.tick_in = 1'b0; sw2.tick_in = 1'b0;
        drive(1, 1'b0, 1'b0, 1'b0);
        drive(2, 1'b0, 1'b0, 1'b0);
        rst1_n = 1'b0; rst2_n = 1'b0;
        cyc(3);
        rst1_n = 1'b1; rst2_n = 1'b1;
        cyc(1);
        for (int d = 1; d <= 2; d++) begin
            check($sformatf("reset%0d time", d),     time_of(d), 24'h0);
            check($sformatf("reset%0d running", d),  24'(run_of(d)), 24'h0);
            check($sformatf("reset%0d overflow", d), 24'(ovf_of(d)), 24'h0);
        end

        run_vecs(0, 12);

        // First change lands two edges after tick_in is first sampled high.
        pulse(1, 1, 0, 0);
        cyc(2);
        ticks(1, 9);
        cyc(3);
        check("latency pre", time_of(1), 24'h000000);
        set_tick(1, 1'b1);
        cyc(1);
        check("latency e0", time_of(1), 24'h000000);
        set_tick(1, 1'b0);
        cyc(1);
        check("latency e1", time_of(1), 24'h000000);
        cyc(1);
        check("latency e2", time_of(1), 24'h000001);
        cyc(2);

        ticks(1, 9);
        cyc(3);
        tick_with(1, 1'b1, 1'b0);
        check("ss+tick time", time_of(1), 24'h000002);
        check("ss+tick running", 24'(run_of(1)), 24'h0);
        pulse(1, 1, 0, 0);
        cyc(2);
        check("resume running", 24'(run_of(1)), 24'h1);
        ticks(1, 9);
        cyc(3);
        tick_with(1, 1'b1, 1'b1);
        check("clr+ss+tick time", time_of(1), 24'h000000);
        check("clr+ss+tick running", 24'(run_of(1)), 24'h0);

        run_vecs(13, 16);

        // A level held high for many cycles counts once.
        pulse(2, 1, 0, 0);
        cyc(2);
        set_tick(2, 1'b1);
        cyc(20);
        set_tick(2, 1'b0);
        cyc(3);
        check("held tick", time_of(2), 24'h000001);
        pulse(2, 0, 1, 0);
        cyc(2);

        run_vecs(17, 18);

        rst2_n = 1'b0;
        cyc(1);
        check("midrun reset time", time_of(2), 24'h000000);
        check("midrun reset running", 24'(run_of(2)), 24'h0);
        rst2_n = 1'b1;
        cyc(2);

        run_vecs(19, 29);

        // Minutes pinned at 59 so the full wrap is reachable in a short run.
        pulse(2, 0, 1, 0);
        cyc(2);
        force dut2.u_min_tens.count = 4'd5;
        force dut2.u_min_ones.count = 4'd9;
        pulse(2, 1, 0, 0);
        cyc(2);
        ticks(2, 5999);
        cyc(3);
        check("pre-wrap time", time_of(2), 24'h595999);
        check("pre-wrap overflow", 24'(ovf_of(2)), 24'h0);
        ticks(2, 1);
        cyc(3);
        check("wrap secs/cs", 24'(time_of(2) & 24'h00FFFF), 24'h000000);
        check("wrap overflow", 24'(ovf_of(2)), 24'h1);
        check("wrap running", 24'(run_of(2)), 24'h1);
        ticks(2, 3);
        cyc(3);
        check("overflow sticky", 24'(ovf_of(2)), 24'h1);
        release dut2.u_min_tens.count;
        release dut2.u_min_ones.count;
        pulse(2, 0, 1, 0);
        cyc(2);
        check("post-clear time", time_of(2), 24'h000000);
        check("post-clear overflow", 24'(ovf_of(2)), 24'h0);
        check("post-clear running", 24'(run_of(2)), 24'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
